oht2bin_pipe: RTL



---
 rtl/oht2bin_pipe_if.sv | 25 ++
 rtl/oht2bin_pipe.sv | 133 +++++++++++++
 2 files changed

// File: rtl/oht2bin_pipe_if.sv
// Handshake bundle for the pipelined one-hot/priority encoder:
// an input vector stream in, an encoded-index stream out.
interface oht2bin_pipe_if #(
    parameter int WIDTH     = 16,
    parameter int WIDTH_LOG = $clog2(WIDTH)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_oht;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_LOG-1:0] out_bin;
    logic                 out_vld;
    logic                 out_err;

    modport master (
        output in_valid, in_oht, out_ready,
        input  in_ready, out_valid, out_bin, out_vld, out_err
    );

    modport slave (
        input  in_valid, in_oht, out_ready,
        output in_ready, out_valid, out_bin, out_vld, out_err
    );
endinterface

// File: rtl/oht2bin_pipe.sv
// Pipelined SPLIT-ary reduction tree turning a one-hot (or priority) vector
// into a binary index; one register stage per tree level, elastic handshake.
module oht2bin_pipe #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 4,
    parameter int MODE  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    oht2bin_pipe_if.slave bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int SPLIT_LOG = $clog2(SPLIT);
    localparam int LEVELS    = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;

    logic [LEVELS:1] stage_valid;
    logic [LEVELS:1] stage_ready;
    logic            chain_rdy;

    // A stage may load when it is empty or its successor drains this cycle.
    always_comb begin
        stage_ready = '0;
        chain_rdy   = bus.out_ready;
        for (int k = LEVELS; k >= 1; k--) begin
            chain_rdy      = !stage_valid[k] || chain_rdy;
            stage_ready[k] = chain_rdy;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : lvl
            localparam int NG = ((WIDTH >> (gi * SPLIT_LOG)) > 0) ?
                                (WIDTH >> (gi * SPLIT_LOG)) : 1;

            // Per-group partial result: any bit seen, multi-hot seen, index so far.
            logic [NG-1:0]        g_vld;
            logic [NG-1:0]        g_err;
            logic [WIDTH_LOG-1:0] g_idx [NG];

            if (gi == 0) begin : leaf
                assign g_vld = bus.in_oht;
                assign g_err = '0;
                for (gj = 0; gj < NG; gj++) begin : zidx
                    assign g_idx[gj] = '0;
                end
            end else begin : node
                localparam int NC = ((WIDTH >> ((gi - 1) * SPLIT_LOG)) > 0) ?
                                    (WIDTH >> ((gi - 1) * SPLIT_LOG)) : 1;
                localparam int NP    = NG * SPLIT;
                localparam int SHIFT = (gi - 1) * SPLIT_LOG;

                logic [NP-1:0]        ch_vld;
                logic [NP-1:0]        ch_err;
                logic [WIDTH_LOG-1:0] ch_idx [NP];
                logic [NG-1:0]        n_vld;
                logic [NG-1:0]        n_err;
                logic [WIDTH_LOG-1:0] n_idx [NG];
                logic                 up_valid;
                logic                 valid_q;

                // Pad the child list to a whole number of groups; missing
                // children (narrow top level) read as empty.
                for (gj = 0; gj < NP; gj++) begin : pad
                    if (gj < NC) begin : live
                        assign ch_vld[gj] = lvl[gi-1].g_vld[gj];
                        assign ch_err[gj] = lvl[gi-1].g_err[gj];
                        assign ch_idx[gj] = lvl[gi-1].g_idx[gj];
                    end else begin : dead
                        assign ch_vld[gj] = 1'b0;
                        assign ch_err[gj] = 1'b0;
                        assign ch_idx[gj] = '0;
                    end
                end

                always_comb begin
                    for (int g = 0; g < NG; g++) begin
                        n_vld[g] = 1'b0;
                        n_err[g] = 1'b0;
                        n_idx[g] = '0;
                        for (int j = 0; j < SPLIT; j++) begin
                            if (ch_vld[g*SPLIT + j]) begin
                                if (MODE == 0) begin
                                    n_err[g] = n_err[g] | n_vld[g] | ch_err[g*SPLIT + j];
                                    n_idx[g] = n_idx[g] | ch_idx[g*SPLIT + j] |
                                               (WIDTH_LOG'(j) << SHIFT);
                                end else if (!n_vld[g]) begin
                                    n_idx[g] = ch_idx[g*SPLIT + j] |
                                               (WIDTH_LOG'(j) << SHIFT);
                                end
                                n_vld[g] = 1'b1;
                            end
                        end
                    end
                end

                if (gi == 1) begin : src_in
                    assign up_valid = bus.in_valid;
                end else begin : src_stage
                    assign up_valid = stage_valid[gi-1];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        valid_q <= 1'b0;
                        g_vld   <= '0;
                        g_err   <= '0;
                        for (int g = 0; g < NG; g++) begin
                            g_idx[g] <= '0;
                        end
                    end else if (stage_ready[gi]) begin
                        valid_q <= up_valid;
                        if (up_valid) begin
                            g_vld <= n_vld;
                            g_err <= n_err;
                            for (int g = 0; g < NG; g++) begin
                                g_idx[g] <= n_idx[g];
                            end
                        end
                    end
                end

                assign stage_valid[gi] = valid_q;
            end
        end
    endgenerate

    assign bus.in_ready  = stage_ready[1];
    assign bus.out_valid = stage_valid[LEVELS];
    assign bus.out_vld   = lvl[LEVELS].g_vld[0];
    assign bus.out_err   = lvl[LEVELS].g_err[0];
    assign bus.out_bin   = lvl[LEVELS].g_idx[0];
endmodule
